// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e         : frame sequencing states common to TX and RX
//   DEFAULT_CLKS_PER_BIT : 217 clocks per bit, i.e. 115200 baud from a 25 MHz clock
//   DATA_BITS/STOP_BITS  : 8N1 framing; FRAME_BITS counts start + data + stop
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 217;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;
    localparam int FRAME_BITS           = 1 + DATA_BITS + STOP_BITS;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts clocks within one serial bit period.
//   i_Clk    : system clock, rising edge
//   i_Rst    : asynchronous active-high reset
//   i_Clear  : hold the count at zero (used while no bit is in progress)
//   i_Enable : advance the count; it wraps to zero after CLKS_PER_BIT-1
//   o_Last   : registered strobe, high while the count sits at CLKS_PER_BIT-1,
//              so the edge that ends this cycle is the bit boundary
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Last
);

    localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             last_q,  last_d;

    // The strobe is derived from the next count so that it is registered
    // yet still lines up with the cycle in which the count equals LAST_COUNT.
    always_comb begin
        count_d = count_q;
        last_d  = 1'b0;
        if (i_Clear) begin
            count_d = '0;
        end else if (i_Enable) begin
            if (count_q == LAST_COUNT) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
            last_d = (count_d == LAST_COUNT);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign o_Last = last_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, one byte per request, LSB first.
//   i_Clk       : system clock, rising edge
//   i_Rst       : asynchronous active-high reset; aborts any frame in flight
//   i_TX_DV     : byte-valid request, only looked at while idle
//   i_TX_Byte   : byte to send, captured on the accepting edge
//   o_TX_Active : high from the accepting edge until the end of the stop bit
//   o_TX_Serial : serial line, idles high
//   o_TX_Done   : one-clock pulse after the stop bit completes
// Every output comes straight from a flop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done
);

    localparam int                IDX_W         = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e            state_q,   state_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q,   shift_d;
    logic                   serial_q,  serial_d;
    logic                   active_q,  active_d;
    logic                   done_q,    done_d;

    logic timer_clear;
    logic timer_enable;
    logic bit_last;

    // The timer only runs while a bit is on the line; it is held at zero
    // otherwise so the start bit begins from a fresh count.
    assign timer_clear  = (state_q == IDLE) || (state_q == CLEANUP);
    assign timer_enable = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Clear (timer_clear),
        .i_Enable(timer_enable),
        .o_Last  (bit_last)
    );

    // Next-state and next-output logic. The line value for the upcoming bit
    // is decided on the boundary edge, so the serial flop always changes
    // exactly on a bit boundary. Data leaves from bit 0 of a right-shifting
    // register.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                if (i_TX_DV) begin
                    shift_d   = i_TX_Byte;
                    bit_idx_d = '0;
                    serial_d  = 1'b0;
                    active_d  = 1'b1;
                    state_d   = START;
                end
            end

            START: begin
                if (bit_last) begin
                    serial_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end

            DATA: begin
                if (bit_last) begin
                    if (bit_idx_q == LAST_DATA_IDX) begin
                        serial_d = 1'b1;
                        state_d  = STOP;
                    end else begin
                        serial_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end

            STOP: begin
                if (bit_last) begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = CLEANUP;
                end
            end

            CLEANUP: begin
                serial_d = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the line to idle at once and
    // discards any frame in progress without signalling completion.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign o_TX_Serial = serial_q;
    assign o_TX_Active = active_q;
    assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. Two instances run side by
// side, one at the default 217 clocks per bit and one at the minimum of 2.
module tb_uart_tx;

   localparam int N_A = 217;
   localparam int N_B = 2;

   logic       clk;
   logic       rst;
   logic       dvA, dvB;
   logic [7:0] byteA, byteB;
   logic       activeA, serialA, doneA;
   logic       activeB, serialB, doneB;

   int checks = 0;
   int errors = 0;
   bit stopAll = 0;

   // Reference state: frame time t counts edges since acceptance, -1 = idle
   int         tA = -1;
   int         tB = -1;
   logic [7:0] mByteA = 8'h00;
   logic [7:0] mByteB = 8'h00;

   uart_tx #(.CLKS_PER_BIT(N_A)) dutA (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .i_TX_DV    (dvA),
      .i_TX_Byte  (byteA),
      .o_TX_Active(activeA),
      .o_TX_Serial(serialA),
      .o_TX_Done  (doneA)
   );

   uart_tx #(.CLKS_PER_BIT(N_B)) dutB (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .i_TX_DV    (dvB),
      .i_TX_Byte  (byteB),
      .o_TX_Active(activeB),
      .o_TX_Serial(serialB),
      .o_TX_Done  (doneB)
   );

   // 40 ns clock
   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic dv, input logic [7:0] b);
      dvA   = dv;
      byteA = b;
   endtask

   // Frame as a bit vector, index 0 = start bit, index 9 = stop bit
   function automatic logic [9:0] frameOf(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   // Expected {serial, active, done} for frame time t with n clocks per bit
   function automatic logic [2:0] expectOut(input int t, input int n, input logic [7:0] b);
      logic [9:0] fr;
      if (t < 0) return 3'b100;
      if (t < 10 * n) begin
         fr = frameOf(b);
         return {fr[t / n], 1'b1, 1'b0};
      end
      if (t == 10 * n) return 3'b101;
      return 3'b100;
   endfunction

   // A request is taken when idle or on the edge ending the cycle after done
   function automatic int nextT(input int t, input int n, input logic dv);
      if (t < 0 || t == 10 * n + 1) return dv ? 0 : -1;
      return t + 1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tA <= -1;
         tB <= -1;
      end else begin
         if (nextT(tA, N_A, dvA) == 0) mByteA <= byteA;
         tA <= nextT(tA, N_A, dvA);
         if (nextT(tB, N_B, dvB) == 0) mByteB <= byteB;
         tB <= nextT(tB, N_B, dvB);
      end
   end

   // Every cycle both instances are compared against the reference
   always @(negedge clk) begin
      checkOutput("lineA", 32'({serialA, activeA, doneA}), 32'(expectOut(tA, N_A, mByteA)));
      checkOutput("lineB", 32'({serialB, activeB, doneB}), 32'(expectOut(tB, N_B, mByteB)));
   end

   function automatic logic lineNow(input bit useB);
      return useB ? serialB : serialA;
   endfunction

   function automatic logic activeNow(input bit useB);
      return useB ? activeB : activeA;
   endfunction

   function automatic logic doneNow(input bit useB);
      return useB ? doneB : doneA;
   endfunction

   // Waits (bounded) for the line to drop, then observes the frame from its
   // first low cycle (c = 0) through the done cycle (c = 10n). lead counts
   // high samples seen before the first low one.
   task automatic captureFrame(input bit useB, output logic [9:0] bits, output int doneAt,
                               output int doneCnt, output int activeCnt, output int lead,
                               output logic [63:0] trace, output bit seen);
      int n;
      n = useB ? N_B : N_A;
      bits = '1; doneAt = -1; doneCnt = 0; activeCnt = 0; lead = 0; trace = '1; seen = 0;
      for (int w = 0; w < 6000; w++) begin
         if (lineNow(useB) == 1'b0) begin
            seen = 1;
            break;
         end
         lead++;
         @(negedge clk);
      end
      if (!seen) return;
      for (int c = 0; c <= 10 * n; c++) begin
         if (c > 0) @(negedge clk);
         if (activeNow(useB)) activeCnt++;
         if (doneNow(useB)) begin
            doneCnt++;
            if (doneAt < 0) doneAt = c;
         end
         if (c < 64) trace[c] = lineNow(useB);
         if ((c % n) == (n / 2) && (c / n) < 10) bits[c / n] = lineNow(useB);
      end
   endtask

   // Main sequence, driving the 217-clock instance
   initial begin
      logic [9:0]  bits;
      logic [63:0] trace;
      int doneAt, doneCnt, activeCnt, lead;
      bit seen;

      rst = 1'b1;
      applyStimulus(1'b0, 8'h00);
      repeat (3) @(negedge clk);
      checkOutput("resetSerialA", 32'(serialA), 32'd1);
      checkOutput("resetActiveA", 32'(activeA), 32'd0);
      checkOutput("resetDoneA",   32'(doneA),   32'd0);
      checkOutput("resetSerialB", 32'(serialB), 32'd1);
      rst = 1'b0;

      // Single byte 0x37
      @(negedge clk); applyStimulus(1'b1, 8'h37);
      @(negedge clk); applyStimulus(1'b0, 8'hFF);
      captureFrame(1'b0, bits, doneAt, doneCnt, activeCnt, lead, trace, seen);
      checkOutput("frame37Seen",   32'(seen), 32'd1);
      checkOutput("frame37Bits",   32'(bits), 32'h26E);
      checkOutput("frame37DoneAt", 32'(doneAt), 32'd2170);
      checkOutput("frame37Dones",  32'(doneCnt), 32'd1);
      checkOutput("frame37Active", 32'(activeCnt), 32'd2170);

      // Busy rejection: requests mid-DATA and during the done/cleanup cycle
      @(negedge clk); applyStimulus(1'b1, 8'h55);
      @(negedge clk); applyStimulus(1'b0, 8'h00);
      fork
         captureFrame(1'b0, bits, doneAt, doneCnt, activeCnt, lead, trace, seen);
         begin
            repeat (5 * N_A) @(negedge clk);
            applyStimulus(1'b1, 8'h0F);
            @(negedge clk); applyStimulus(1'b0, 8'h0F);
            for (int w = 0; w < 6000 && doneA !== 1'b1; w++) @(negedge clk);
            applyStimulus(1'b1, 8'h0F);
            @(negedge clk); applyStimulus(1'b0, 8'h0F);
         end
      join
      checkOutput("busyBits",  32'(bits), 32'(frameOf(8'h55)));
      checkOutput("busyDones", 32'(doneCnt), 32'd1);
      repeat (3 * N_A) @(negedge clk);
      checkOutput("busyLineIdle",   32'(serialA), 32'd1);
      checkOutput("busyActiveIdle", 32'(activeA), 32'd0);

      // Back-to-back with DV held high
      @(negedge clk); applyStimulus(1'b1, 8'h81);
      for (int f = 0; f < 3; f++) begin
         captureFrame(1'b0, bits, doneAt, doneCnt, activeCnt, lead, trace, seen);
         checkOutput("b2bBits",  32'(bits), 32'(frameOf(8'h81)));
         checkOutput("b2bDones", 32'(doneCnt), 32'd1);
         if (f > 0) checkOutput("b2bGap", 32'(lead), 32'd2);
      end
      applyStimulus(1'b0, 8'h00);
      repeat (5) @(negedge clk);
      checkOutput("b2bStopped", 32'(activeA), 32'd0);

      // Reset during data bit 3 of 0x3C
      @(negedge clk); applyStimulus(1'b1, 8'h3C);
      @(negedge clk); applyStimulus(1'b0, 8'h3C);
      repeat (4 * N_A + 100) @(negedge clk);
      checkOutput("preRstSerial", 32'(serialA), 32'd1);
      checkOutput("preRstActive", 32'(activeA), 32'd1);
      #5 rst = 1'b1;
      #1;
      checkOutput("rstSerial", 32'(serialA), 32'd1);
      checkOutput("rstActive", 32'(activeA), 32'd0);
      checkOutput("rstDone",   32'(doneA),   32'd0);
      applyStimulus(1'b1, 8'h3C);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk); applyStimulus(1'b0, 8'h00);
      captureFrame(1'b0, bits, doneAt, doneCnt, activeCnt, lead, trace, seen);
      checkOutput("rstReleaseLead", 32'(lead), 32'd0);
      checkOutput("rstResendBits",  32'(bits), 32'(frameOf(8'h3C)));
      checkOutput("rstResendDone",  32'(doneAt), 32'd2170);

      // Random requests and byte churn, checked by the reference every cycle
      for (int i = 0; i < 9000; i++) begin
         @(negedge clk);
         applyStimulus(($urandom_range(0, 199) == 0), 8'($urandom));
      end
      applyStimulus(1'b0, 8'h00);
      repeat (2200) @(negedge clk);
      checkOutput("finalIdle", 32'(activeA), 32'd0);

      stopAll = 1;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Second sequence, driving the 2-clock instance
   initial begin
      logic [9:0]  bits;
      logic [63:0] trace;
      int doneAt, doneCnt, activeCnt, lead;
      bit seen;

      dvB   = 1'b0;
      byteB = 8'h00;
      @(negedge clk);
      for (int w = 0; w < 100 && rst; w++) @(negedge clk);
      @(negedge clk); dvB = 1'b1; byteB = 8'hC3;
      @(negedge clk); dvB = 1'b0; byteB = 8'h00;
      captureFrame(1'b1, bits, doneAt, doneCnt, activeCnt, lead, trace, seen);
      checkOutput("smallSeen",   32'(seen), 32'd1);
      checkOutput("smallBits",   32'(bits), 32'h386);
      checkOutput("smallTrace",  32'(trace[19:0]), 32'hFC03C);
      checkOutput("smallDoneAt", 32'(doneAt), 32'd20);
      checkOutput("smallActive", 32'(activeCnt), 32'd20);

      while (!stopAll) begin
         @(negedge clk);
         dvB   = ($urandom_range(0, 3) == 0);
         byteB = 8'($urandom);
      end
   end

endmodule
